// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encodings and a small response-selection helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        B_RESP
    } w_state_t;

    // Map an address-decode hit/miss onto the AXI response code.
    function automatic logic [1:0] resp_of(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-organised storage for the AXI4-Lite responder. Combinational read
// port, synchronous byte-masked write port. Contents are never reset.
module sram_array #(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read is combinational so a same-cycle write is seen only afterwards.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder backed by an on-chip word array. Independent read and
// write FSMs, each holding one outstanding request, respond LATENCY cycles
// after acceptance (LATENCY must be at least 1). Out-of-range addresses
// return SLVERR and never touch the array.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH + 1)'(DEPTH * STRB_W);

    // Offset from BASE_ADDR with one extra bit, so addresses below the base
    // wrap to a huge value and fail the single upper-bound comparison.
    function automatic logic [ADDR_WIDTH:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    // ---------------- read-side state ----------------
    r_state_t              r_state_q;
    logic [CNT_W-1:0]      r_cnt_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // ---------------- write-side state ----------------
    w_state_t              w_state_q;
    logic [CNT_W-1:0]      w_cnt_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // ---------------- decode / array signals ----------------
    logic [ADDR_WIDTH:0]   rd_off_d;
    logic [ADDR_WIDTH:0]   wr_off_d;
    logic                  rd_in_range_d;
    logic                  wr_in_range_d;
    logic [IDX_W-1:0]      rd_idx_d;
    logic [IDX_W-1:0]      wr_idx_d;
    logic                  wr_we_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  aw_hs_d;
    logic                  w_hs_d;
    logic                  aw_have_d;
    logic                  w_have_d;

    // Address decode for the latched read and write addresses.
    always_comb begin
        rd_off_d      = addr_offset(araddr_q);
        wr_off_d      = addr_offset(awaddr_q);
        rd_in_range_d = (rd_off_d < SPAN);
        wr_in_range_d = (wr_off_d < SPAN);
        rd_idx_d      = rd_off_d[LANE_W +: IDX_W];
        wr_idx_d      = wr_off_d[LANE_W +: IDX_W];
    end

    // Write-channel handshakes and "payload available" terms for this cycle.
    always_comb begin
        aw_hs_d   = (w_state_q == W_IDLE) && awvalid && awready_q;
        w_hs_d    = (w_state_q == W_IDLE) && wvalid && wready_q;
        aw_have_d = aw_hs_d || !awready_q;
        w_have_d  = w_hs_d || !wready_q;
    end

    // Array write strobe: only in the write's final wait cycle, only in range,
    // and never while reset is asserted so a reset drops the pending write.
    always_comb begin
        wr_we_d = rst_n && (w_state_q == W_WAIT) && (w_cnt_q == '0) && wr_in_range_d;
    end

    sram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .STRB_W     (STRB_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_we_d),
        .waddr_i (wr_idx_d),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .raddr_i (rd_idx_d),
        .rdata_o (mem_rdata)
    );

    // Read FSM: accept AR, count down the latency, sample, hold until rready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            araddr_q  <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        araddr_q  <= araddr;
                        r_cnt_q   <= CNT_LOAD;
                        arready_q <= 1'b0;
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == '0) begin
                        rdata_q   <= rd_in_range_d ? mem_rdata : '0;
                        rresp_q   <= resp_of(rd_in_range_d);
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: collect AW and W in any order, wait, commit, hold B until bready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_d) begin
                        awaddr_q  <= awaddr;
                        awready_q <= 1'b0;
                    end
                    if (w_hs_d) begin
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        wready_q <= 1'b0;
                    end
                    if (aw_have_d && w_have_d) begin
                        w_cnt_q   <= CNT_LOAD;
                        w_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q == '0) begin
                        bresp_q   <= resp_of(wr_in_range_d);
                        bvalid_q  <= 1'b1;
                        w_state_q <= B_RESP;
                    end else begin
                        w_cnt_q <= w_cnt_q - CNT_W'(1);
                    end
                end
                B_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Self-checking bench for axil_sram_slave: directed transactions with literal
// expectations plus a cycle-by-cycle timestamp-based reference model.
module tb_axil_sram_slave;

    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    always #5 clk = ~clk;

    axil_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [int];

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    logic        e_arready = 1'b1, e_rvalid = 1'b0, e_awready = 1'b1, e_wready = 1'b1, e_bvalid = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [1:0]  e_rresp = 2'b00, e_bresp = 2'b00;
    bit          e_rknown = 1'b1;
    bit          rd_busy = 0, aw_got = 0, w_got = 0, wr_sched = 0;
    int          rd_due = 0, wr_due = 0, nxt = 0;
    logic [31:0] m_raddr = '0, m_waddr = '0, m_wdata = '0, m_word = '0;
    logic [3:0]  m_wstrb = '0;
    logic        c_ar, c_rv, c_aw, c_w, c_bv;

    // Every cycle: compare the DUT against the model, then advance the model
    // to the values expected after the next rising edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("m_arready", 32'(arready), 32'(e_arready));
            chk("m_rvalid",  32'(rvalid),  32'(e_rvalid));
            chk("m_rresp",   32'(rresp),   32'(e_rresp));
            if (e_rknown) chk("m_rdata", rdata, e_rdata);
            chk("m_awready", 32'(awready), 32'(e_awready));
            chk("m_wready",  32'(wready),  32'(e_wready));
            chk("m_bvalid",  32'(bvalid),  32'(e_bvalid));
            chk("m_bresp",   32'(bresp),   32'(e_bresp));
        end
        if (!rst_n) begin
            e_arready = 1'b1; e_rvalid = 1'b0; e_rdata = '0; e_rresp = 2'b00; e_rknown = 1'b1;
            e_awready = 1'b1; e_wready = 1'b1; e_bvalid = 1'b0; e_bresp = 2'b00;
            rd_busy = 0; aw_got = 0; w_got = 0; wr_sched = 0;
        end else begin
            nxt  = cyc + 1;
            c_ar = e_arready; c_rv = e_rvalid; c_aw = e_awready; c_w = e_wready; c_bv = e_bvalid;
            if (c_ar && arvalid) begin
                rd_busy = 1; m_raddr = araddr; rd_due = nxt + LAT; e_arready = 1'b0;
            end
            if (c_rv && rready) begin
                e_rvalid = 1'b0; e_arready = 1'b1;
            end
            // Read sample happens before this edge's array write: old data wins.
            if (rd_busy && nxt == rd_due) begin
                rd_busy  = 0;
                e_rvalid = 1'b1;
                if (in_rng(m_raddr)) begin
                    e_rresp  = 2'b00;
                    e_rknown = mem_m.exists(idx_of(m_raddr));
                    if (e_rknown) e_rdata = mem_m[idx_of(m_raddr)];
                end else begin
                    e_rresp = 2'b10; e_rdata = '0; e_rknown = 1'b1;
                end
            end
            if (c_aw && awvalid) begin
                aw_got = 1; m_waddr = awaddr; e_awready = 1'b0;
            end
            if (c_w && wvalid) begin
                w_got = 1; m_wdata = wdata; m_wstrb = wstrb; e_wready = 1'b0;
            end
            if (aw_got && w_got && !wr_sched) begin
                wr_sched = 1; wr_due = nxt + LAT;
            end
            if (wr_sched && nxt == wr_due) begin
                e_bvalid = 1'b1;
                if (in_rng(m_waddr)) begin
                    e_bresp = 2'b00;
                    m_word  = mem_m.exists(idx_of(m_waddr)) ? mem_m[idx_of(m_waddr)] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_word[8*b +: 8] = m_wdata[8*b +: 8];
                    mem_m[idx_of(m_waddr)] = m_word;
                end else begin
                    e_bresp = 2'b10;
                end
            end
            if (c_bv && bready) begin
                e_bvalid = 1'b0; e_awready = 1'b1; e_wready = 1'b1;
                aw_got = 0; w_got = 0; wr_sched = 0;
            end
        end
    end

    // ---------------- directed transaction tasks ----------------
    task automatic do_read(input logic [31:0] a, input logic [31:0] xd, input logic [1:0] xr,
                           input string tag);
        int n;
        int hs;
        @(posedge clk); #2;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!arready && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_arready"}, 32'(arready), 1);
        hs = cyc + 1;
        @(posedge clk); #2;
        arvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_ar_drop"}, 32'(arready), 0);
        n = 0;
        while (!rvalid && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_rvalid"}, 32'(rvalid), 1);
        chk({tag, "_rlat"}, 32'(cyc - hs), LAT);
        chk({tag, "_rdata"}, rdata, xd);
        chk({tag, "_rresp"}, 32'(rresp), 32'(xr));
        $display("read  addr=%h rdata=%h rresp=%0d latency=%0d", a, rdata, rresp, cyc - hs);
        @(posedge clk); #2;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] xr, input int lead, input string tag);
        int n;
        int hs_aw;
        int last;
        @(posedge clk); #2;
        awaddr = a; awvalid = 1'b1; bready = 1'b1;
        if (lead == 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        @(negedge clk);
        n = 0;
        while (!awready && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_awready"}, 32'(awready), 1);
        hs_aw = cyc + 1;
        last  = hs_aw;
        @(posedge clk); #2;
        awvalid = 1'b0;
        if (lead == 0) wvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_aw_drop"}, 32'(awready), 0);
        if (lead == 0) begin
            chk({tag, "_w_drop"}, 32'(wready), 0);
        end else begin
            repeat (lead - 1) @(posedge clk);
            #2;
            wdata = d; wstrb = s; wvalid = 1'b1;
            @(negedge clk);
            chk({tag, "_wready"}, 32'(wready), 1);
            chk({tag, "_aw_held"}, 32'(awready), 0);
            last = cyc + 1;
            @(posedge clk); #2;
            wvalid = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (!bvalid && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 32'(bvalid), 1);
        chk({tag, "_blat"}, 32'(cyc - last), LAT);
        chk({tag, "_bresp"}, 32'(bresp), 32'(xr));
        $display("write addr=%h wdata=%h wstrb=%h bresp=%0d latency=%0d", a, d, s, bresp, cyc - last);
        @(posedge clk); #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, 32'(arready), 1);
        chk({tag, "_awready"}, 32'(awready), 1);
        chk({tag, "_wready"},  32'(wready),  1);
        chk({tag, "_rvalid"},  32'(rvalid),  0);
        chk({tag, "_bvalid"},  32'(bvalid),  0);
        chk({tag, "_rdata"},   rdata,        0);
        chk({tag, "_rresp"},   32'(rresp),   0);
        chk({tag, "_bresp"},   32'(bresp),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst");

        // Full write and readback, then a single-lane partial write.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, "w_full");
        do_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00, "r_full");
        do_write(32'h8000_0010, 32'h0000_1200, 4'b0010, 2'b00, 0, "w_part");
        do_read (32'h8000_0010, 32'hDEAD_12EF, 2'b00, "r_part");

        // AW leads W by three cycles.
        do_write(32'h8000_0040, 32'h55AA_33CC, 4'hF, 2'b00, 3, "w_lead");
        do_read (32'h8000_0040, 32'h55AA_33CC, 2'b00, "r_lead");

        // First and last words of the array.
        do_write(32'h8000_0000, 32'h0102_0304, 4'hF, 2'b00, 0, "w_first");
        do_write(32'h8000_3FFC, 32'hA5A5_0001, 4'hF, 2'b00, 0, "w_last");
        do_read (32'h8000_3FFC, 32'hA5A5_0001, 2'b00, "r_last");

        // Out-of-range read and write; word 0 (the wrap alias) stays intact.
        do_read (32'h7FFF_FFFC, 32'h0000_0000, 2'b10, "r_oor");
        do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, "w_oor");
        do_read (32'h8000_0000, 32'h0102_0304, 2'b00, "r_alias");

        // Zero-strobe write is a no-op that still answers OKAY.
        do_write(32'h8000_0040, 32'h0000_0000, 4'h0, 2'b00, 0, "w_nostrb");
        do_read (32'h8000_0040, 32'h55AA_33CC, 2'b00, "r_nostrb");

        // Back-pressure: concurrent read and write, responses held 5 cycles.
        @(posedge clk); #2;
        rready = 1'b0; bready = 1'b0;
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("hold_arready_in", 32'(arready), 1);
        chk("hold_awready_in", 32'(awready), 1);
        @(posedge clk); #2;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(rvalid && bvalid) && n < 40) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("hold_rvalid",  32'(rvalid),  1);
            chk("hold_bvalid",  32'(bvalid),  1);
            chk("hold_arready", 32'(arready), 0);
            chk("hold_rdata",   rdata,        32'hDEAD_12EF);
            chk("hold_rresp",   32'(rresp),   0);
            chk("hold_bresp",   32'(bresp),   0);
            $display("hold  cycle=%0d rvalid=%0d bvalid=%0d rdata=%h", k, rvalid, bvalid, rdata);
            @(negedge clk);
        end
        @(posedge clk); #2;
        rready = 1'b1; bready = 1'b1;
        repeat (2) @(posedge clk);
        do_read (32'h8000_0020, 32'h1234_5678, 2'b00, "r_hold");

        // Reset while both FSMs are waiting: nothing completes, array intact.
        @(posedge clk); #2;
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0010; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("rst_mid_arready", 32'(arready), 1);
        chk("rst_mid_awready", 32'(awready), 1);
        @(posedge clk); #2;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        for (int k = 0; k < 8; k++) begin
            chk("rst_no_rvalid", 32'(rvalid), 0);
            chk("rst_no_bvalid", 32'(bvalid), 0);
            @(negedge clk);
        end
        $display("reset mid-transaction released at cycle %0d", cyc);
        do_read (32'h8000_0010, 32'hDEAD_12EF, 2'b00, "r_after_rst");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
